// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory; data first, fetch never starved past STARVE_LIMIT.
// Grant to ready takes 2+N cycles (N = memory wait cycles); requesters hold their level request until their ready pulse.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ready,
  output logic        m_en,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_ack,
  output logic        busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_V = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          m_en_q, m_en_d;
  logic          m_we_q, m_we_d;
  logic [15:0]   m_addr_q, m_addr_d;
  logic [15:0]   m_wdata_q, m_wdata_d;
  logic [15:0]   i_rdata_q, i_rdata_d;
  logic [15:0]   d_rdata_q, d_rdata_d;
  logic          i_ready_q, i_ready_d;
  logic          d_ready_q, d_ready_d;

  logic d_req;
  logic grant_i;
  logic grant_d;

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    m_en_d    = m_en_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    d_req     = d_read | d_write;
    grant_i   = 1'b0;
    grant_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // A fetch that has watched STARVE_LIMIT data grants go by jumps the queue once.
        if (d_req && i_req && (streak_q == LIMIT_V)) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end

        if (grant_d) begin
          state_d   = DBUSY;
          m_en_d    = 1'b1;
          m_we_d    = d_write;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (i_req && (streak_q != LIMIT_V)) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (grant_i) begin
          state_d  = IBUSY;
          m_en_d   = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = i_addr;
          streak_d = '0;
        end

        if (!i_req) begin
          streak_d = '0;
        end
      end

      IBUSY: begin
        if (m_ack) begin
          state_d   = RESP;
          m_en_d    = 1'b0;
          i_rdata_d = m_rdata;
          i_ready_d = 1'b1;
        end
      end

      DBUSY: begin
        if (m_ack) begin
          state_d   = RESP;
          m_en_d    = 1'b0;
          d_ready_d = 1'b1;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end

      RESP: begin
        // Dead cycle lets the owner drop its request before arbitration resumes.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 16'h0000;
      m_wdata_q <= 16'h0000;
      i_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
    end
  end

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = 16'h0;
  logic [15:0] i_rdata;
  logic        i_ready;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [15:0] d_addr = 16'h0;
  logic [15:0] d_wdata = 16'h0;
  logic [15:0] d_rdata;
  logic        d_ready;
  logic        m_en;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata = 16'h0;
  logic        m_ack = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0; m_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_en, m_we, i_ready, d_ready, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {m_en, m_we, i_ready, d_ready, busy});
    end
    checks++;
    if ({m_addr, m_wdata, i_rdata, d_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {m_addr, m_wdata, i_rdata, d_rdata});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_fetch_zero_wait();
    i_req = 1'b1; i_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if ({m_en, m_we, m_addr} !== {1'b1, 1'b0, 16'h0010}) begin
      failures++;
      $display("FAIL fetch_grant en=%b we=%b addr=%h exp 1 0 0010", m_en, m_we, m_addr);
    end
    m_ack = 1'b1; m_rdata = 16'hA5A5;
    @(negedge clk);
    checks++;
    if ({i_ready, d_ready, i_rdata} !== {1'b1, 1'b0, 16'hA5A5}) begin
      failures++;
      $display("FAIL fetch_ready i_ready=%b d_ready=%b i_rdata=%h exp 1 0 a5a5", i_ready, d_ready, i_rdata);
    end
    i_req = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({i_ready, busy, m_en} !== 3'b000) begin
      failures++;
      $display("FAIL fetch_pulse_once i_ready=%b busy=%b m_en=%b exp 000", i_ready, busy, m_en);
    end
  endtask

  task automatic test_load_wait();
    d_read = 1'b1; d_addr = 16'h0200;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({m_en, m_we, d_ready, i_ready, m_addr} !== {4'b1000, 16'h0200}) begin
        failures++;
        $display("FAIL load_wait c=%0d en=%b we=%b d_ready=%b i_ready=%b addr=%h", c, m_en, m_we, d_ready, i_ready, m_addr);
      end
      if (c == 4) begin m_ack = 1'b1; m_rdata = 16'h1234; end
    end
    @(negedge clk);
    checks++;
    if ({d_ready, i_ready, d_rdata} !== {2'b10, 16'h1234}) begin
      failures++;
      $display("FAIL load_ready d_ready=%b i_ready=%b d_rdata=%h exp 1 0 1234", d_ready, i_ready, d_rdata);
    end
    d_read = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_ready, busy} !== 2'b00) begin
      failures++;
      $display("FAIL load_pulse_once d_ready=%b busy=%b exp 00", d_ready, busy);
    end
  endtask

  task automatic test_simultaneous();
    i_req = 1'b1; i_addr = 16'h0020;
    d_write = 1'b1; d_addr = 16'h0300; d_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({m_en, m_we, m_addr, m_wdata} !== {2'b11, 16'h0300, 16'hBEEF}) begin
      failures++;
      $display("FAIL simul_data_first en=%b we=%b addr=%h wdata=%h", m_en, m_we, m_addr, m_wdata);
    end
    m_ack = 1'b1; m_rdata = 16'h9999;
    @(negedge clk);
    checks++;
    if ({d_ready, i_ready, d_rdata} !== {2'b10, 16'h1234}) begin
      failures++;
      $display("FAIL simul_store_ready d_ready=%b i_ready=%b d_rdata=%h exp 1 0 1234", d_ready, i_ready, d_rdata);
    end
    d_write = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, m_en} !== 2'b00) begin failures++; $display("FAIL simul_resp_gap busy=%b m_en=%b", busy, m_en); end
    @(negedge clk);
    checks++;
    if ({m_en, m_we, m_addr} !== {2'b10, 16'h0020}) begin
      failures++;
      $display("FAIL simul_fetch_next en=%b we=%b addr=%h exp 1 0 0020", m_en, m_we, m_addr);
    end
    m_ack = 1'b1; m_rdata = 16'h5555;
    @(negedge clk);
    checks++;
    if ({i_ready, i_rdata} !== {1'b1, 16'h5555}) begin
      failures++;
      $display("FAIL simul_fetch_ready i_ready=%b i_rdata=%h exp 1 5555", i_ready, i_rdata);
    end
    i_req = 1'b0; m_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int n = 0;
    int budget = 0;
    logic [15:0] exp_addr;
    i_req = 1'b1; i_addr = 16'h0AAA;
    d_read = 1'b1; d_addr = 16'h0DDD;
    m_ack = 1'b1; m_rdata = 16'h7777;
    while (n < 3 * (LIMIT + 1) && budget < 200) begin
      @(negedge clk);
      budget++;
      if (m_en === 1'b1) begin
        exp_addr = ((n % (LIMIT + 1)) == LIMIT) ? 16'h0AAA : 16'h0DDD;
        checks++;
        if (m_addr !== exp_addr) begin
          failures++;
          $display("FAIL starve_grant n=%0d addr=%h exp=%h", n, m_addr, exp_addr);
        end
        n++;
      end
    end
    checks++;
    if (n < 3 * (LIMIT + 1)) begin
      failures++;
      $display("FAIL starve_timeout grants=%0d exp=%0d", n, 3 * (LIMIT + 1));
    end
    idle_inputs();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    d_read = 1'b1; d_addr = 16'h0600;
    @(negedge clk);
    checks++;
    if ({m_en, busy} !== 2'b11) begin failures++; $display("FAIL rstmid_dbusy en=%b busy=%b exp 11", m_en, busy); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_en, busy, d_ready} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_async en=%b busy=%b d_ready=%b exp 000", m_en, busy, d_ready);
    end
    d_read = 1'b0; m_ack = 1'b1; m_rdata = 16'hDEAD;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({d_ready, busy, m_en} !== 3'b000) begin
        failures++;
        $display("FAIL rstmid_late_ack c=%0d d_ready=%b busy=%b en=%b exp 000", c, d_ready, busy, m_en);
      end
    end
    m_ack = 1'b0;
    i_req = 1'b1; i_addr = 16'h0042;
    @(negedge clk);
    checks++;
    if ({m_en, m_addr} !== {1'b1, 16'h0042}) begin
      failures++;
      $display("FAIL rstmid_resume en=%b addr=%h exp 1 0042", m_en, m_addr);
    end
    m_ack = 1'b1; m_rdata = 16'h0BAD;
    @(negedge clk);
    checks++;
    if ({i_ready, i_rdata} !== {1'b1, 16'h0BAD}) begin
      failures++;
      $display("FAIL rstmid_resume_ready i_ready=%b i_rdata=%h exp 1 0bad", i_ready, i_rdata);
    end
    i_req = 1'b0; m_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_input_change();
    d_read = 1'b1; d_addr = 16'h0400;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({m_en, m_addr} !== {1'b1, 16'h0400}) begin
        failures++;
        $display("FAIL hold_addr c=%0d en=%b addr=%h exp 1 0400", c, m_en, m_addr);
      end
      d_addr = 16'h0500;
      if (c == 3) begin m_ack = 1'b1; m_rdata = 16'h4444; end
    end
    @(negedge clk);
    checks++;
    if ({d_ready, d_rdata} !== {1'b1, 16'h4444}) begin
      failures++;
      $display("FAIL hold_ready d_ready=%b d_rdata=%h exp 1 4444", d_ready, d_rdata);
    end
    d_read = 1'b0; m_ack = 1'b0;
    @(negedge clk);
  endtask

  // Model tracks transactions: who is granted, how long memory stalls, what each read returns.
  task automatic test_random();
    logic [15:0] mem [256];
    int phase, owner, wait_left, streak, kind;
    logic        exp_we;
    logic [15:0] exp_addr, exp_wdata, exp_ir, exp_dr;
    bit          ip, dp;
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    phase = 0; owner = 0; wait_left = 0; streak = 0;
    exp_we = 1'b0; exp_addr = 16'h0; exp_wdata = 16'h0; exp_ir = 16'h0; exp_dr = 16'h0;
    ip = 1'b0; dp = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      checks++;
      if (busy !== (phase != 0)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b", cyc, busy); end
      checks++;
      if (m_en !== (phase == 1)) begin failures++; $display("FAIL rnd_m_en cyc=%0d got=%b", cyc, m_en); end
      if (phase == 1) begin
        checks++;
        if ({m_we, m_addr} !== {exp_we, exp_addr}) begin
          failures++;
          $display("FAIL rnd_grant cyc=%0d we=%b addr=%h exp we=%b addr=%h", cyc, m_we, m_addr, exp_we, exp_addr);
        end
        if (exp_we) begin
          checks++;
          if (m_wdata !== exp_wdata) begin
            failures++;
            $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, m_wdata, exp_wdata);
          end
        end
      end
      checks++;
      if ({i_ready, d_ready} !== {(phase == 2 && owner == 0), (phase == 2 && owner == 1)}) begin
        failures++;
        $display("FAIL rnd_ready cyc=%0d i=%b d=%b phase=%0d owner=%0d", cyc, i_ready, d_ready, phase, owner);
      end
      checks++;
      if ({i_rdata, d_rdata} !== {exp_ir, exp_dr}) begin
        failures++;
        $display("FAIL rnd_rdata cyc=%0d i=%h d=%h exp i=%h d=%h", cyc, i_rdata, d_rdata, exp_ir, exp_dr);
      end

      if (phase == 2 && owner == 0) ip = 1'b0;
      if (phase == 2 && owner == 1) dp = 1'b0;
      if (!ip && $urandom_range(0, 2) == 0) begin ip = 1'b1; i_addr = 16'($urandom); end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1'b1;
        kind = $urandom_range(0, 2);
        d_read = (kind != 1); d_write = (kind != 0);
        d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if (phase == 1 && owner == 1 && $urandom_range(0, 1) == 1) begin
        d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if (phase == 1 && owner == 0 && $urandom_range(0, 1) == 1) i_addr = 16'($urandom);
      i_req = ip;
      if (!dp) begin d_read = 1'b0; d_write = 1'b0; end

      if (phase == 1) begin
        m_ack = (wait_left == 0);
        m_rdata = mem[exp_addr[7:0]];
      end else begin
        m_ack = ($urandom_range(0, 3) == 0);
        m_rdata = 16'($urandom);
      end

      case (phase)
        0: begin
          if ((d_read || d_write) && (!i_req || streak < LIMIT)) begin
            owner = 1; phase = 1;
            exp_we = d_write; exp_addr = d_addr; exp_wdata = d_wdata;
            streak = i_req ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
            wait_left = $urandom_range(0, 3);
          end else if (i_req) begin
            owner = 0; phase = 1;
            exp_we = 1'b0; exp_addr = i_addr;
            streak = 0;
            wait_left = $urandom_range(0, 3);
          end else begin
            streak = 0;
          end
        end
        1: begin
          if (wait_left == 0) begin
            phase = 2;
            if (exp_we) mem[exp_addr[7:0]] = exp_wdata;
            else if (owner == 0) exp_ir = mem[exp_addr[7:0]];
            else exp_dr = mem[exp_addr[7:0]];
          end else begin
            wait_left--;
          end
        end
        default: phase = 0;
      endcase
    end
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch_zero_wait();
    test_load_wait();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_input_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
